// File: rtl/sample_to_duty.sv
// Sample FIFO feeding the PWM stage: pops one signed sample per PWM period and
// converts it to an N-bit duty magnitude plus direction. Option: SAMPLE_TO_DUTY_HOLD_EN.
module sample_to_duty #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [W-1:0]           in_sample,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   period_start,
  output logic [N-1:0]           duty,
  output logic                   dir,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop_req;
  logic          pop;
  logic [W-1:0]  head;
  logic [W-2:0]  mag;
  logic          unused_mag;

  assign in_ready = !rst && (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop_req  = period_start && ena;
  assign pop      = pop_req && (level != '0);
  assign head     = mem[rd_ptr];

  // Magnitude from the low W-1 bits; the most negative code wraps to zero and saturates.
  always_comb begin
    mag = '0;
    if (!head[W-1]) begin
      mag = head[W-2:0];
    end else if (head[W-2:0] == '0) begin
      mag = '1;
    end else begin
      mag = ~head[W-2:0] + (W-1)'(1);
    end
  end

  assign unused_mag = ^mag;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      duty     <= '0;
      dir      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end

      if (!ena) begin
        duty <= '0;
      end else if (pop) begin
        duty <= mag[W-2 -: N];
        dir  <= head[W-1];
      end else if (pop_req) begin
        underrun <= 1'b1;
`ifndef SAMPLE_TO_DUTY_HOLD_EN
        duty     <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sample_to_duty.sv
// Bench for sample_to_duty: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_sample_to_duty;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef SAMPLE_TO_DUTY_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int UR_D = HOLD ? 10 : 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [W-1:0] in_sample;
  logic         in_valid;
  logic         in_ready;
  logic         period_start;
  logic [N-1:0] duty;
  logic         dir;
  logic         underrun;
  logic [2:0]   level;

  sample_to_duty #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .period_start(period_start),
    .duty(duty), .dir(dir), .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ena, valid;
    logic [7:0] sample;
    logic       ps;
    int         duty, dir, ur, lvl, rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] q[$];
  int m_duty = 0, m_dir = 0, m_ur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, e, v, input logic [7:0] s, input logic p,
                     input int d, di, u, l, rd);
    vec_t t;
    t.rst = r; t.ena = e; t.valid = v; t.sample = s; t.ps = p;
    t.duty = d; t.dir = di; t.ur = u; t.lvl = l; t.rdy = rd;
    vecs.push_back(t);
  endtask

  function automatic void convert(input logic [W-1:0] s, output int d, output int di);
    int sv, mag;
    sv  = $signed(s);
    mag = (sv < 0) ? -sv : sv;
    if (mag > (1 << (W-1)) - 1) mag = (1 << (W-1)) - 1;
    d  = mag >> (W-1-N);
    di = (sv < 0) ? 1 : 0;
  endfunction

  // One clock: drive, check in_ready before the edge, advance model, check outputs after.
  task automatic step(input logic r, e, v, input logic [W-1:0] s, input logic p, input int t_rdy);
    bit m_ready, do_push;
    logic [W-1:0] smp;
    rst = r; ena = e; in_valid = v; in_sample = s; period_start = p;
    #2;
    m_ready = !r && (q.size() != DEPTH);
    check("in_ready", 32'(in_ready), 32'(m_ready));
    if (t_rdy >= 0) check("tbl_in_ready", 32'(in_ready), t_rdy);
    if (r) begin
      q.delete(); m_duty = 0; m_dir = 0; m_ur = 0;
    end else begin
      do_push = v && m_ready;
      if (!e) m_duty = 0;
      else if (p) begin
        if (q.size() > 0) begin
          smp = q.pop_front();
          convert(smp, m_duty, m_dir);
        end else begin
          m_ur = 1;
          if (!HOLD) m_duty = 0;
        end
      end
      if (do_push) q.push_back(s);
    end
    @(posedge clk);
    #1;
    check("duty", 32'(duty), m_duty);
    check("dir", 32'(dir), m_dir);
    check("underrun", 32'(underrun), m_ur);
    check("level", 32'(level), q.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //  rst ena v  sample ps | duty dir ur lvl rdy
    add(1, 1, 0, 8'h00, 0,    0,   0,  0, 0,  0);
    add(0, 1, 1, 8'h50, 0,    0,   0,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,   10,   0,  0, 0,  1);
    add(0, 1, 1, 8'hB0, 0,   10,   0,  0, 1,  1);
    add(0, 1, 1, 8'h80, 0,   10,   0,  0, 2,  1);
    add(0, 1, 0, 8'h00, 1,   10,   1,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,   15,   1,  0, 0,  1);
    add(0, 1, 1, 8'h07, 0,   15,   1,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,    0,   0,  0, 0,  1);
    add(0, 1, 1, 8'h11, 0,    0,   0,  0, 1,  1);
    add(0, 1, 1, 8'h22, 0,    0,   0,  0, 2,  1);
    add(0, 1, 1, 8'h33, 0,    0,   0,  0, 3,  1);
    add(0, 1, 1, 8'h44, 0,    0,   0,  0, 4,  1);
    add(0, 1, 1, 8'h55, 0,    0,   0,  0, 4,  0);
    add(0, 1, 1, 8'h55, 1,    2,   0,  0, 3,  0);
    add(0, 1, 0, 8'h00, 1,    4,   0,  0, 2,  1);
    add(0, 1, 0, 8'h00, 1,    6,   0,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,    8,   0,  0, 0,  1);
    add(0, 1, 1, 8'hA0, 0,    8,   0,  0, 1,  1);
    add(0, 1, 1, 8'hC0, 0,    8,   0,  0, 2,  1);
    add(0, 1, 1, 8'hF8, 1,   12,   1,  0, 2,  1);
    add(0, 1, 0, 8'h00, 1,    8,   1,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,    1,   1,  0, 0,  1);
    add(0, 1, 1, 8'h50, 0,    1,   1,  0, 1,  1);
    add(0, 1, 0, 8'h00, 1,   10,   0,  0, 0,  1);
    add(0, 1, 0, 8'h00, 1, UR_D,   0,  1, 0,  1);
    add(0, 1, 1, 8'h30, 1, UR_D,   0,  1, 1,  1);
    add(0, 1, 0, 8'h00, 1,    6,   0,  1, 0,  1);
    add(0, 1, 1, 8'h90, 0,    6,   0,  1, 1,  1);
    add(0, 0, 0, 8'h00, 1,    0,   0,  1, 1,  1);
    add(0, 0, 1, 8'h70, 1,    0,   0,  1, 2,  1);
    add(0, 1, 0, 8'h00, 1,   14,   1,  1, 1,  1);
    add(0, 0, 1, 8'h10, 1,    0,   1,  1, 2,  1);
    add(0, 1, 1, 8'h20, 0,    0,   1,  1, 3,  1);
    add(1, 1, 1, 8'h40, 1,    0,   0,  0, 0,  0);
    add(0, 1, 0, 8'h00, 0,    0,   0,  0, 0,  1);

    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_sample = '0; period_start = 1'b0;
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].valid, vecs[i].sample, vecs[i].ps, vecs[i].rdy);
      check($sformatf("tbl_duty[%0d]", i), 32'(duty), vecs[i].duty);
      check($sformatf("tbl_dir[%0d]", i), 32'(dir), vecs[i].dir);
      check($sformatf("tbl_underrun[%0d]", i), 32'(underrun), vecs[i].ur);
      check($sformatf("tbl_level[%0d]", i), 32'(level), vecs[i].lvl);
    end

    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1,
           W'($urandom),
           $urandom_range(0, 2) == 0,
           -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
